// File: rtl/cell_stream_pkg.sv
// ============================================================================
// Module      : cell_stream_pkg
// Description : Shared packet type, beat indices and framing state encoding
//               for the cell stream output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cell_stream_pkg;

    localparam int PKT_BEATS = 4;

    localparam logic [1:0] BEAT_HDR = 2'd0;
    localparam logic [1:0] BEAT_X   = 2'd1;
    localparam logic [1:0] BEAT_Y   = 2'd2;
    localparam logic [1:0] BEAT_S   = 2'd3;

    typedef struct packed {
        logic [31:0] header;
        logic [31:0] datax;
        logic [31:0] datay;
        logic [31:0] datas;
    } cell_pkt_t;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_DRAIN   = 1'b1
    } frame_state_t;

endpackage

`default_nettype wire

// File: rtl/cell_stream_obuf_if.sv
// ============================================================================
// Module      : cell_stream_obuf_if
// Description : Beat stream from the cell fabric plus flat packet words
//               towards the harness.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cell_stream_obuf_if;

    logic        tvalid;
    logic        tlast;
    logic [31:0] tdata;
    logic        tready;

    logic        stream_out_valid;
    logic        stream_out_ack;
    logic [31:0] stream_out_header;
    logic [31:0] stream_out_datax;
    logic [31:0] stream_out_datay;
    logic [31:0] stream_out_datas;

    // The buffer itself
    modport slave (
        input  tvalid, tlast, tdata, stream_out_ack,
        output tready, stream_out_valid,
        output stream_out_header, stream_out_datax, stream_out_datay, stream_out_datas
    );

    // Fabric and harness side
    modport master (
        output tvalid, tlast, tdata, stream_out_ack,
        input  tready, stream_out_valid,
        input  stream_out_header, stream_out_datax, stream_out_datay, stream_out_datas
    );

endinterface

`default_nettype wire

// File: rtl/cell_pkt_fifo2.sv
// ============================================================================
// Module      : cell_pkt_fifo2
// Description : Two-entry packet FIFO with a registered head word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cell_pkt_fifo2
    import cell_stream_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  cell_pkt_t  din,
    input  logic       pop,
    output logic [1:0] count,
    output logic [1:0] count_next,
    output cell_pkt_t  head
);

    cell_pkt_t  r_mem [0:1];
    logic       r_wr;
    logic       r_rd;
    logic [1:0] r_count;
    cell_pkt_t  r_head;

    logic       w_push;
    logic       w_pop;
    logic       w_rd_next;
    logic [1:0] w_count_next;
    cell_pkt_t  w_head_next;

    always_comb begin
        w_pop        = pop && (r_count != 2'd0);
        w_push       = push && ((r_count != 2'd2) || w_pop);
        w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
        w_rd_next    = r_rd ^ w_pop;
        // Head must show a packet written this same edge when it lands in the read slot
        if (w_count_next == 2'd0)
            w_head_next = '0;
        else if (w_push && (r_wr == w_rd_next))
            w_head_next = din;
        else
            w_head_next = r_mem[w_rd_next];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_count  <= 2'd0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= din;
                r_wr        <= ~r_wr;
            end
            r_rd    <= w_rd_next;
            r_count <= w_count_next;
            r_head  <= w_head_next;
        end
    end

    assign count      = r_count;
    assign count_next = w_count_next;
    assign head       = r_head;

endmodule

`default_nettype wire

// File: rtl/cell_stream_obuf.sv
// ============================================================================
// Module      : cell_stream_obuf
// Description : Reassembles 4-beat cell stream packets into a 2-deep packet
//               FIFO, discarding and counting malformed packets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cell_stream_obuf
    import cell_stream_pkg::*;
#(
    parameter string NAME  = "",
    parameter int    ERR_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cell_stream_obuf_if.slave    bus,
    output logic                 frame_err,
    output logic [ERR_W-1:0]     frame_err_count
);

    frame_state_t     r_state;
    logic             r_tready;
    logic [1:0]       r_bcnt;
    logic [31:0]      r_asm [0:2];
    logic             r_frame_err;
    logic [ERR_W-1:0] r_err_cnt;

    logic             w_accept;
    logic             w_collect;
    logic             w_last_slot;
    logic             w_push;
    logic             w_bad;
    cell_pkt_t        w_pkt;
    logic [1:0]       w_count;
    logic [1:0]       w_count_next;
    cell_pkt_t        w_head;

    assign w_accept    = bus.tvalid && r_tready;
    assign w_collect   = (r_state == ST_COLLECT);
    assign w_last_slot = (r_bcnt == BEAT_S);
    assign w_push      = w_accept && w_collect && w_last_slot && bus.tlast;
    // Runt (tlast early) and overlong (no tlast on the fourth beat) both mismatch here
    assign w_bad       = w_accept && w_collect && (w_last_slot != bus.tlast);

    always_comb begin
        w_pkt.header = r_asm[0];
        w_pkt.datax  = r_asm[1];
        w_pkt.datay  = r_asm[2];
        w_pkt.datas  = bus.tdata;
    end

    cell_pkt_fifo2 u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_push),
        .din        (w_pkt),
        .pop        (bus.stream_out_ack),
        .count      (w_count),
        .count_next (w_count_next),
        .head       (w_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_COLLECT;
            r_tready    <= 1'b0;
            r_bcnt      <= BEAT_HDR;
            r_asm[0]    <= 32'd0;
            r_asm[1]    <= 32'd0;
            r_asm[2]    <= 32'd0;
            r_frame_err <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            // Looking at the post-edge occupancy keeps a full FIFO from ever taking a beat
            r_tready    <= (w_count_next < 2'd2);
            r_frame_err <= w_bad;
            if (w_bad && (r_err_cnt != {ERR_W{1'b1}}))
                r_err_cnt <= r_err_cnt + 1'b1;

            if (w_accept) begin
                case (r_state)
                    ST_COLLECT: begin
                        case (r_bcnt)
                            BEAT_HDR: r_asm[0] <= bus.tdata;
                            BEAT_X:   r_asm[1] <= bus.tdata;
                            BEAT_Y:   r_asm[2] <= bus.tdata;
                            default:  ;
                        endcase
                        if (bus.tlast || w_last_slot)
                            r_bcnt <= BEAT_HDR;
                        else
                            r_bcnt <= r_bcnt + 2'd1;
                        if (w_last_slot && !bus.tlast)
                            r_state <= ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        if (bus.tlast)
                            r_state <= ST_COLLECT;
                    end
                    default: r_state <= ST_COLLECT;
                endcase
            end
        end
    end

    assign bus.tready            = r_tready;
    assign bus.stream_out_valid  = (w_count != 2'd0);
    assign bus.stream_out_header = w_head.header;
    assign bus.stream_out_datax  = w_head.datax;
    assign bus.stream_out_datay  = w_head.datay;
    assign bus.stream_out_datas  = w_head.datas;
    assign frame_err             = r_frame_err;
    assign frame_err_count       = r_err_cnt;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && w_push)
            $display("%s: pkt 0x%x", NAME, r_asm[0]);
        if (rst_n && w_bad)
            $display("%s: pkt 0x%x", NAME, (r_bcnt == BEAT_HDR) ? bus.tdata : r_asm[0]);
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cell_stream_obuf.sv
// ============================================================================
// Module      : tb_cell_stream_obuf
// Description : Directed and randomized checks of cell_stream_obuf against a
//               packet-level queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cell_stream_obuf;
    import cell_stream_pkg::*;

    localparam int ERR_W = 3;
    localparam int SAT   = (1 << ERR_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cell_stream_obuf_if bus ();
    logic             frame_err;
    logic [ERR_W-1:0] frame_err_count;

    cell_stream_obuf #(.NAME("obuf"), .ERR_W(ERR_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .frame_err       (frame_err),
        .frame_err_count (frame_err_count)
    );

    int        tests = 0;
    int        fails = 0;
    cell_pkt_t exp_q [$];
    int        exp_pulses = 0;
    int        exp_cnt    = 0;
    int        pulse_cnt  = 0;

    always @(negedge clk) if (frame_err === 1'b1) pulse_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08x expected 0x%08x", tag, obs, exp);
        end
    endtask

    task automatic chk_now(input string tag);
        cell_pkt_t h;
        h = (exp_q.size() != 0) ? exp_q[0] : '0;
        chk({tag, ".valid"},  {31'd0, bus.stream_out_valid}, {31'd0, exp_q.size() != 0});
        chk({tag, ".header"}, bus.stream_out_header, h.header);
        chk({tag, ".datax"},  bus.stream_out_datax,  h.datax);
        chk({tag, ".datay"},  bus.stream_out_datay,  h.datay);
        chk({tag, ".datas"},  bus.stream_out_datas,  h.datas);
        chk({tag, ".tready"}, {31'd0, bus.tready},   {31'd0, exp_q.size() < 2});
        chk({tag, ".errcnt"}, {{(32-ERR_W){1'b0}}, frame_err_count}, exp_cnt);
        chk({tag, ".pulses"}, pulse_cnt, exp_pulses);
    endtask

    task automatic check_state(input string tag);
        @(negedge clk); #1;
        chk_now(tag);
    endtask

    // Entered and left just after a falling edge
    task automatic send_beat(input logic [31:0] d, input logic last, input bit gaps);
        int n;
        int budget;
        if (gaps) begin
            n = $urandom_range(0, 3);
            repeat (n) begin
                bus.tvalid = 1'b0;
                bus.tdata  = $urandom;
                @(negedge clk);
            end
        end
        bus.tvalid = 1'b1;
        bus.tdata  = d;
        bus.tlast  = last;
        budget = 0;
        while (bus.tready !== 1'b1 && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 300) chk("tready_timeout", 32'(budget), 32'd0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_packet(input logic [7:0][31:0] w, input int n, input bit gaps);
        cell_pkt_t p;
        for (int i = 0; i < n; i++) send_beat(w[i], i == n - 1, gaps);
        bus.tvalid = 1'b0;
        bus.tlast  = 1'b0;
        if (n == PKT_BEATS) begin
            p.header = w[0]; p.datax = w[1]; p.datay = w[2]; p.datas = w[3];
            exp_q.push_back(p);
        end else begin
            exp_pulses++;
            exp_cnt = (exp_cnt < SAT) ? exp_cnt + 1 : SAT;
        end
    endtask

    task automatic do_ack();
        @(negedge clk); #1;
        bus.stream_out_ack = 1'b1;
        @(posedge clk);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge clk);
        bus.stream_out_ack = 1'b0;
    endtask

    task automatic rand_words(output logic [7:0][31:0] w);
        for (int i = 0; i < 8; i++) w[i] = $urandom;
    endtask

    logic [7:0][31:0] w0, w1, w2, w3;
    cell_pkt_t        pn;

    initial begin
        bus.tvalid = 1'b0; bus.tlast = 1'b0; bus.tdata = 32'd0; bus.stream_out_ack = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst.tready", {31'd0, bus.tready}, 32'd0);
        chk("rst.valid",  {31'd0, bus.stream_out_valid}, 32'd0);
        chk("rst.header", bus.stream_out_header, 32'd0);
        chk("rst.ferr",   {31'd0, frame_err}, 32'd0);
        chk("rst.errcnt", {{(32-ERR_W){1'b0}}, frame_err_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rel.tready", {31'd0, bus.tready}, 32'd1);

        // Ack with nothing queued is ignored
        do_ack();
        check_state("ack_empty");

        // Single packet and its latency
        w0 = '0;
        w0[0] = 32'hA0000001; w0[1] = 32'h11; w0[2] = 32'h22; w0[3] = 32'h33;
        send_packet(w0, 4, 1'b0);
        #1;
        chk("single.latency", {31'd0, bus.stream_out_valid}, 32'd1);
        check_state("single");
        do_ack();
        check_state("single_pop");

        // Three back-to-back packets without ack
        rand_words(w1); rand_words(w2); rand_words(w3);
        send_packet(w1, 4, 1'b0);
        send_packet(w2, 4, 1'b0);
        #1;
        chk("full.tready", {31'd0, bus.tready}, 32'd0);
        fork
            send_packet(w3, 4, 1'b0);
            begin
                repeat (4) @(negedge clk);
                #1;
                chk_now("stall");
                do_ack();
            end
        join
        check_state("three.a");
        do_ack();
        check_state("three.b");
        do_ack();
        check_state("three.c");

        // 2-beat runt, then a good packet
        rand_words(w0); rand_words(w1);
        send_packet(w0, 2, 1'b0);
        send_packet(w1, 4, 1'b0);
        check_state("runt");
        do_ack();
        check_state("runt_pop");

        // 6-beat overlong, then a good packet
        rand_words(w0); rand_words(w1);
        send_packet(w0, 6, 1'b0);
        send_packet(w1, 4, 1'b0);
        check_state("long");
        do_ack();

        // Same packet with gaps and without
        rand_words(w0);
        send_packet(w0, 4, 1'b1);
        check_state("gaps");
        send_packet(w0, 4, 1'b0);
        check_state("nogaps");
        do_ack();
        do_ack();

        // Randomized mix of lengths, gaps and acks
        for (int it = 0; it < 16; it++) begin
            int n;
            n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 4;
            rand_words(w0);
            if (exp_q.size() == 2 || $urandom_range(0, 1) == 1) do_ack();
            send_packet(w0, n, 1'($urandom_range(0, 1)));
            check_state("rand");
        end
        while (exp_q.size() != 0) do_ack();

        // Push and ack on the same edge with one packet queued
        rand_words(w0); rand_words(w1);
        send_packet(w0, 4, 1'b0);
        for (int i = 0; i < 3; i++) send_beat(w1[i], 1'b0, 1'b0);
        bus.tvalid = 1'b1; bus.tdata = w1[3]; bus.tlast = 1'b1;
        bus.stream_out_ack = 1'b1;
        @(posedge clk);
        void'(exp_q.pop_front());
        pn.header = w1[0]; pn.datax = w1[1]; pn.datay = w1[2]; pn.datas = w1[3];
        exp_q.push_back(pn);
        @(negedge clk);
        bus.tvalid = 1'b0; bus.tlast = 1'b0; bus.stream_out_ack = 1'b0;
        #1;
        chk_now("push_pop");

        // Reset mid-packet with one packet queued
        for (int i = 0; i < 3; i++) send_beat(w0[i], 1'b0, 1'b0);
        bus.tvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_cnt = 0;
        chk("mrst.valid",  {31'd0, bus.stream_out_valid}, 32'd0);
        chk("mrst.header", bus.stream_out_header, 32'd0);
        chk("mrst.datas",  bus.stream_out_datas, 32'd0);
        chk("mrst.tready", {31'd0, bus.tready}, 32'd0);
        chk("mrst.errcnt", {{(32-ERR_W){1'b0}}, frame_err_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rand_words(w1);
        send_packet(w1, 4, 1'b0);
        check_state("after_rst");
        do_ack();

        // Error counter saturation with single-beat runts
        for (int i = 0; i < SAT + 2; i++) begin
            rand_words(w0);
            send_packet(w0, 1, 1'b0);
        end
        check_state("saturate");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
